// File: rtl/logic_op_arbiter.sv
// logic_op_arbiter: round-robin shared AND/OR/XOR/NOT/TST unit with Z/N/C/V flags
//
// Ports:
//   clk, rst                          rising-edge clock, synchronous active-high reset
//   req0_valid/ready/op/a/b           requester 0 handshake, opcode and operands
//   req1_valid/ready/op/a/b           requester 1 handshake, opcode and operands
//   resp_valid, resp_ready            response handshake
//   resp_id                           requester that issued the operation
//   resp_result                       operation result (TST: AND value)
//   resp_wb                           result is to be written back
//   resp_err                          illegal opcode
//   resp_zero/negative/carry/overflow flags of the computed result
module logic_op_arbiter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [2:0]       req0_op,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [2:0]       req1_op,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic             resp_id,
   output logic [WIDTH-1:0] resp_result,
   output logic             resp_wb,
   output logic             resp_err,
   output logic             resp_zero,
   output logic             resp_negative,
   output logic             resp_carry,
   output logic             resp_overflow
);
   typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;
   state_t state, next_state;
   logic             last_grant;
   logic             gnt;
   logic             accept;
   logic [2:0]       op_q;
   logic [WIDTH-1:0] a_q, b_q;
   logic             id_q;
   logic [WIDTH-1:0] res;
   logic             wb, err, zero;
   // On contention the requester that did not win last time is preferred.
   assign gnt    = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
   assign accept = req0_ready | req1_ready;
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    next_state = (req0_valid || req1_valid) ? EXEC : IDLE;
         EXEC:    next_state = HOLD;
         HOLD:    next_state = resp_ready ? IDLE : HOLD;
         default: next_state = IDLE;
      endcase
   end
   // Ready depends only on state, last_grant and the valids (no path from resp_ready).
   always_comb begin
      req0_ready = !rst && state == IDLE && req0_valid && !gnt;
      req1_ready = !rst && state == IDLE && req1_valid && gnt;
      resp_valid = state == HOLD;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant <= 1'b1;
         op_q       <= '0;
         a_q        <= '0;
         b_q        <= '0;
         id_q       <= 1'b0;
      end else if (accept) begin
         last_grant <= gnt;
         id_q       <= gnt;
         op_q       <= gnt ? req1_op : req0_op;
         a_q        <= gnt ? req1_a  : req0_a;
         b_q        <= gnt ? req1_b  : req0_b;
      end
   end
   always_comb begin
      res = '0;
      wb  = 1'b0;
      err = 1'b0;
      case (op_q)
         3'b000:  begin res = a_q & b_q; wb = 1'b1; end
         3'b001:  begin res = a_q | b_q; wb = 1'b1; end
         3'b010:  begin res = a_q ^ b_q; wb = 1'b1; end
         3'b011:  begin res = ~a_q;      wb = 1'b1; end
         3'b100:  res = a_q & b_q;
         default: err = 1'b1;
      endcase
   end
   // Illegal opcodes report no flags, so the zero flag is suppressed for them.
   assign zero = !err && res == '0;
   always_ff @(posedge clk) begin
      if (rst) begin
         resp_id       <= 1'b0;
         resp_result   <= '0;
         resp_wb       <= 1'b0;
         resp_err      <= 1'b0;
         resp_zero     <= 1'b0;
         resp_negative <= 1'b0;
         resp_carry    <= 1'b0;
         resp_overflow <= 1'b0;
      end else if (state == EXEC) begin
         resp_id       <= id_q;
         resp_result   <= res;
         resp_wb       <= wb;
         resp_err      <= err;
         resp_zero     <= zero;
         resp_negative <= res[WIDTH-1];
         resp_carry    <= 1'b0;
         resp_overflow <= 1'b0;
      end
   end
endmodule

// File: tb/tb_logic_op_arbiter.sv
// tb_logic_op_arbiter: directed self-checking bench for logic_op_arbiter
module tb_logic_op_arbiter;
   localparam logic [2:0] OP_AND = 3'b000, OP_OR = 3'b001, OP_XOR = 3'b010,
                          OP_NOT = 3'b011, OP_TST = 3'b100, OP_BAD = 3'b110;
   logic        clk = 1'b0;
   logic        rst;
   logic        req0_valid, req0_ready, req1_valid, req1_ready;
   logic [2:0]  req0_op, req1_op;
   logic [15:0] req0_a, req0_b, req1_a, req1_b;
   logic        resp_valid, resp_ready, resp_id, resp_wb, resp_err;
   logic [15:0] resp_result;
   logic        resp_zero, resp_negative, resp_carry, resp_overflow;
   int          n_cmp = 0;
   int          n_err = 0;
   logic [15:0] exp_res [4];
   logic        exp_id  [4];
   int          idx;
   logic_op_arbiter #(.WIDTH(16)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
      .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
      .req1_a(req1_a), .req1_b(req1_b),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
      .resp_result(resp_result), .resp_wb(resp_wb), .resp_err(resp_err),
      .resp_zero(resp_zero), .resp_negative(resp_negative),
      .resp_carry(resp_carry), .resp_overflow(resp_overflow)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic issue(input logic id, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
      if (id) begin
         req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
      end else begin
         req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
      end
      #1;
      check("ready_winner", id ? req1_ready : req0_ready, 1);
      check("ready_loser", id ? req0_ready : req1_ready, 0);
      @(posedge clk); #1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      check("exec_no_valid", resp_valid, 0);
   endtask
   task automatic take(input logic id, input logic [15:0] res, input logic wb, input logic err,
                       input logic z, input logic n);
      @(posedge clk); #1;
      check("resp_valid", resp_valid, 1);
      check("result", resp_result, res);
      check("id", resp_id, id);
      check("wb_err", {resp_wb, resp_err}, {wb, err});
      check("flags_zncv", {resp_zero, resp_negative, resp_carry, resp_overflow}, {z, n, 2'b00});
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      check("resp_consumed", resp_valid, 0);
   endtask
   initial begin
      rst = 1'b1; resp_ready = 1'b0;
      req0_valid = 1'b1; req0_op = OP_AND; req0_a = '0; req0_b = '0;
      req1_valid = 1'b1; req1_op = OP_AND; req1_a = '0; req1_b = '0;
      @(posedge clk); @(posedge clk); #1;
      check("rst_ready0", req0_ready, 0);
      check("rst_ready1", req1_ready, 0);
      check("rst_resp_valid", resp_valid, 0);
      check("rst_resp", {resp_id, resp_result, resp_wb, resp_err, resp_zero, resp_negative,
                         resp_carry, resp_overflow}, 0);
      req0_valid = 1'b0; req1_valid = 1'b0; rst = 1'b0;
      @(posedge clk); #1;
      issue(0, OP_AND, 16'h000B, 16'h000C);
      take(0, 16'h0008, 1, 0, 0, 0);
      issue(1, OP_TST, 16'hAAAA, 16'h5555);
      take(1, 16'h0000, 0, 0, 1, 0);
      issue(1, OP_TST, 16'hFFFF, 16'hFFFF);
      take(1, 16'hFFFF, 0, 0, 0, 1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      req0_valid = 1'b1; req0_op = OP_OR;  req0_a = 16'h00F0; req0_b = 16'h000F;
      req1_valid = 1'b1; req1_op = OP_XOR; req1_a = 16'hFFFF; req1_b = 16'h0001;
      resp_ready = 1'b1;
      exp_id  = '{1'b0, 1'b1, 1'b0, 1'b1};
      exp_res = '{16'h00FF, 16'hFFFE, 16'h00FF, 16'hFFFE};
      idx = 0;
      for (int c = 0; c < 40 && idx < 4; c++) begin
         @(posedge clk); #1;
         if (resp_valid) begin
            check("alt_id", resp_id, exp_id[idx]);
            check("alt_result", resp_result, exp_res[idx]);
            idx++;
         end
      end
      check("alt_count", idx, 4);
      req0_valid = 1'b0; req1_valid = 1'b0;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      issue(0, OP_XOR, 16'h00FF, 16'h0F0F);
      @(posedge clk); #1;
      for (int i = 0; i < 5; i++) begin
         req0_valid = 1'b1; req1_valid = 1'b1;
         #1;
         check("hold_valid", resp_valid, 1);
         check("hold_result", resp_result, 16'h0FF0);
         check("hold_ready", {req0_ready, req1_ready}, 0);
         @(posedge clk); #1;
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      check("hold_released", resp_valid, 0);
      req1_valid = 1'b1;
      #1;
      check("idle_after_hold", req1_ready, 1);
      req1_valid = 1'b0;
      #1;
      issue(0, OP_BAD, 16'h1234, 16'h0000);
      take(0, 16'h0000, 0, 1, 0, 0);
      issue(1, OP_OR, 16'h1200, 16'h0034);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("exec_rst_valid", resp_valid, 0);
      check("exec_rst_resp", {resp_id, resp_result, resp_wb, resp_err, resp_zero, resp_negative,
                              resp_carry, resp_overflow}, 0);
      @(posedge clk); #1;
      check("exec_rst_no_resp", resp_valid, 0);
      issue(0, OP_NOT, 16'h0000, 16'hFFFF);
      take(0, 16'hFFFF, 1, 0, 0, 1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
